pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h00000000: value loaded into PCResult on Reset.
REQ-003 Parameter INCR, default 4: sequential increment, a power of two >= 1.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries, a power of two >= 2.
REQ-005 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 Reset  input  1  reset; synchronous, active-high.
REQ-007 PCWrite  input  1  1 = PC may advance or redirect; 0 = stall (hold).
REQ-008 ExcValid  input  1  exception redirect request.
REQ-009 ExcVector  input  WIDTH  exception target address.
REQ-010 Jump  input  1  unconditional redirect to JumpTarget.
REQ-011 JumpTarget  input  WIDTH  jump, call and fallback-return target.
REQ-012 Call  input  1  qualifies Jump as a call; pushes the return address.
REQ-013 Return  input  1  return; pops the RAS.
REQ-014 BranchTaken  input  1  conditional branch resolved taken.
REQ-015 BranchTarget  input  WIDTH  branch target.
REQ-016 PCResult  output  WIDTH  current PC, registered.
REQ-017 PCNext  output  WIDTH  PCResult+INCR, combinational from PCResult.
REQ-018 RASCount  output  clog2(RAS_DEPTH)+1  valid RAS entries, registered.
REQ-019 RASMiss  output  1  one-cycle registered pulse: Return taken with RAS empty.
REQ-020 MisalignErr  output  1  one-cycle registered pulse: accepted target had nonzero low log2(INCR) bits.

Function
REQ-021 Per-edge priority SHALL be: Reset > ExcValid > !PCWrite > Return > Jump (with or without Call) > BranchTaken > sequential.
REQ-022 ExcValid SHALL load ExcVector regardless of PCWrite, clear RASCount to 0, and ignore all other requests that cycle.
REQ-023 When PCWrite=0 and ExcValid=0, PCResult, the RAS and RASCount SHALL hold, and RASMiss and MisalignErr SHALL be 0 next cycle.
REQ-024 Sequential update SHALL be PCResult <= PCResult+INCR modulo 2^WIDTH; all-ones minus INCR+1 wraps to 0.
REQ-025 Return with RASCount>0 SHALL load the top entry and decrement RASCount.
REQ-026 Return with RASCount=0 SHALL load JumpTarget, leave RASCount at 0, and pulse RASMiss.
REQ-027 Jump with Call=0 SHALL load JumpTarget and leave the RAS unchanged.
REQ-028 Jump with Call=1 SHALL load JumpTarget and push PCResult+INCR.
REQ-029 A push at RASCount<RAS_DEPTH SHALL increment RASCount.
REQ-030 A push at RASCount=RAS_DEPTH SHALL overwrite the oldest entry (circular), keeping RASCount at RAS_DEPTH.
REQ-031 Call asserted without Jump SHALL be ignored.
REQ-032 Return and Call in the same cycle SHALL act as Return only; no push.
REQ-033 BranchTaken SHALL load BranchTarget only when no higher-priority request is active.
REQ-034 Any loaded target (ExcVector, JumpTarget, BranchTarget, or a RAS entry) SHALL have its low log2(INCR) bits forced to 0; MisalignErr pulses if any were 1.
REQ-035 The RAS SHALL be a circular buffer with a top pointer; entries are not cleared on pop.

Reset
REQ-036 While Reset=1 at a rising edge: PCResult <= RESET_VECTOR, RASCount <= 0, RASMiss <= 0, MisalignErr <= 0, top pointer <= 0; all other inputs ignored.
REQ-037 Reset asserted during any operation SHALL take effect at the next edge with no partial update retained.
REQ-038 RAS entry contents need not be reset.
REQ-039 Before the first reset edge, outputs are undefined.

Verification (WIDTH=32, RESET_VECTOR=0, INCR=4, RAS_DEPTH=4)
REQ-040 Reset, then 3 cycles with PCWrite=1 and no requests -> PCResult 0,4,8,C; PCNext 4,8,C,10.
REQ-041 PC=0x100; PCWrite=0 for 2 cycles while Jump=1, JumpTarget=0x200 -> PC holds 0x100; with PCWrite=1 -> 0x200.
REQ-042 Five calls from PCs 0x10,0x20,0x30,0x40,0x50, then five returns -> RASCount saturates at 4; returns load 0x54,0x44,0x34,0x24; fifth return loads JumpTarget with a RASMiss pulse.
REQ-043 Same cycle ExcValid=1 (ExcVector=0x80000180), Jump=1, BranchTaken=1, PCWrite=0 -> PC=0x80000180, RASCount=0.
REQ-044 BranchTaken with BranchTarget=0x00000106 -> PC=0x104, MisalignErr pulses for exactly one cycle.
REQ-045 PC=0xFFFFFFFC, sequential -> PC=0; Reset asserted mid-call sequence -> PC=0, RASCount=0 next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a circular return-address stack.
//   Clk, Reset           : clock, synchronous active-high reset
//   PCWrite              : 1 = advance/redirect, 0 = hold
//   ExcValid/ExcVector   : exception redirect (ignores PCWrite)
//   Jump/JumpTarget/Call : jump, call (push PC+INCR), fallback return target
//   Return               : pop RAS into PC
//   BranchTaken/Target   : taken conditional branch
//   PCResult/PCNext      : registered PC and PC+INCR
//   RASCount             : valid RAS entries
//   RASMiss/MisalignErr  : one-cycle status pulses
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INCR         = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       PCWrite,
    input  logic                       ExcValid,
    input  logic [WIDTH-1:0]           ExcVector,
    input  logic                       Jump,
    input  logic [WIDTH-1:0]           JumpTarget,
    input  logic                       Call,
    input  logic                       Return,
    input  logic                       BranchTaken,
    input  logic [WIDTH-1:0]           BranchTarget,
    output logic [WIDTH-1:0]           PCResult,
    output logic [WIDTH-1:0]           PCNext,
    output logic [$clog2(RAS_DEPTH):0] RASCount,
    output logic                       RASMiss,
    output logic                       MisalignErr
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] INC  = WIDTH'(INCR);
    localparam logic [WIDTH-1:0] MASK = WIDTH'(INCR - 1);
    localparam logic [CW-1:0]    FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d, tgt;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    top_q, top_d;
    logic             miss_q, miss_d, mis_q, mis_d;
    logic             live, pop, push, redirect;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    assign PCResult    = pc_q;
    assign PCNext      = pc_q + INC;
    assign RASCount    = cnt_q;
    assign RASMiss     = miss_q;
    assign MisalignErr = mis_q;

    // top_q is the next write slot; the top entry lives at top_q-1, so a push
    // at full depth naturally overwrites the oldest entry.
    always_comb begin
        live     = PCWrite && !ExcValid;
        pop      = live && Return && cnt_q != '0;
        miss_d   = live && Return && cnt_q == '0;
        push     = live && !Return && Jump && Call;
        redirect = ExcValid || (live && (Return || Jump || BranchTaken));
        tgt      = ExcValid ? ExcVector :
                   Return   ? (pop ? ras_q[top_q - PW'(1)] : JumpTarget) :
                   Jump     ? JumpTarget : BranchTarget;
        mis_d    = redirect && |(tgt & MASK);
        pc_d     = redirect ? (tgt & ~MASK) : live ? PCNext : pc_q;
        cnt_d    = ExcValid ? '0 : pop ? cnt_q - CW'(1) :
                   (push && cnt_q != FULL) ? cnt_q + CW'(1) : cnt_q;
        top_d    = ExcValid ? '0 : pop ? top_q - PW'(1) :
                   push ? top_q + PW'(1) : top_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q   <= RESET_VECTOR;
            cnt_q  <= '0;
            top_q  <= '0;
            miss_q <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            top_q  <= top_d;
            miss_q <= miss_d;
            mis_q  <= mis_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && push) ras_q[top_q] <= PCNext;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer with default parameters.
module tb_pc_sequencer;
    logic        Clk = 1'b0;
    logic        Reset, PCWrite, ExcValid, Jump, Call, Return, BranchTaken;
    logic [31:0] ExcVector, JumpTarget, BranchTarget;
    logic [31:0] PCResult, PCNext;
    logic [2:0]  RASCount;
    logic        RASMiss, MisalignErr;
    int          checks = 0;
    int          errors = 0;

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .ExcValid(ExcValid),
        .ExcVector(ExcVector), .Jump(Jump), .JumpTarget(JumpTarget),
        .Call(Call), .Return(Return), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .PCResult(PCResult), .PCNext(PCNext),
        .RASCount(RASCount), .RASMiss(RASMiss), .MisalignErr(MisalignErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ExcValid = 0; Jump = 0; Call = 0; Return = 0; BranchTaken = 0;
    endtask

    initial begin
        logic [31:0] rets [4];
        rets = '{32'h54, 32'h44, 32'h34, 32'h24};
        Reset = 1; PCWrite = 0; idle();
        ExcVector = 0; JumpTarget = 0; BranchTarget = 0;
        step();
        check("rst_pc", PCResult, 32'h0);
        check("rst_next", PCNext, 32'h4);
        check("rst_cnt", 32'(RASCount), 32'd0);
        check("rst_miss", 32'(RASMiss), 32'd0);
        check("rst_mis", 32'(MisalignErr), 32'd0);
        Reset = 0; PCWrite = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_pc", PCResult, 32'(4 * i));
            check("seq_next", PCNext, 32'(4 * i + 4));
        end
        Jump = 1; JumpTarget = 32'h100;
        step();
        check("jmp_pc", PCResult, 32'h100);
        PCWrite = 0; JumpTarget = 32'h200;
        step();
        check("stall1", PCResult, 32'h100);
        step();
        check("stall2", PCResult, 32'h100);
        PCWrite = 1;
        step();
        check("unstall", PCResult, 32'h200);
        Jump = 0; Call = 1;
        step();
        check("call_nojmp_pc", PCResult, 32'h204);
        check("call_nojmp_cnt", 32'(RASCount), 32'd0);
        Call = 0; Jump = 1; JumpTarget = 32'h10;
        step();
        check("to10", PCResult, 32'h10);
        Call = 1;
        for (int i = 1; i <= 5; i++) begin
            JumpTarget = 32'(16 * (i + 1));
            step();
            check("call_pc", PCResult, 32'(16 * (i + 1)));
            check("call_cnt", 32'(RASCount), (i > 4) ? 32'd4 : 32'(i));
        end
        idle(); Return = 1; JumpTarget = 32'h300;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ret_pc", PCResult, rets[i]);
            check("ret_cnt", 32'(RASCount), 32'(3 - i));
            check("ret_miss", 32'(RASMiss), 32'd0);
        end
        step();
        check("miss_pc", PCResult, 32'h300);
        check("miss_cnt", 32'(RASCount), 32'd0);
        check("miss_pulse", 32'(RASMiss), 32'd1);
        Return = 0;
        step();
        check("miss_end_pc", PCResult, 32'h304);
        check("miss_end", 32'(RASMiss), 32'd0);
        Jump = 1; Call = 1; JumpTarget = 32'h400;
        step();
        check("push_cnt", 32'(RASCount), 32'd1);
        Return = 1; JumpTarget = 32'h500;
        step();
        check("retcall_pc", PCResult, 32'h308);
        check("retcall_cnt", 32'(RASCount), 32'd0);
        idle(); Jump = 1; JumpTarget = 32'h600; BranchTaken = 1; BranchTarget = 32'h700;
        step();
        check("jmp_over_br", PCResult, 32'h600);
        Jump = 0; BranchTarget = 32'h106;
        step();
        check("br_pc", PCResult, 32'h104);
        check("mis_pulse", 32'(MisalignErr), 32'd1);
        idle();
        step();
        check("mis_end_pc", PCResult, 32'h108);
        check("mis_end", 32'(MisalignErr), 32'd0);
        Jump = 1; Call = 1; JumpTarget = 32'h40;
        step();
        check("push2_cnt", 32'(RASCount), 32'd1);
        Call = 0; ExcValid = 1; ExcVector = 32'h80000180; BranchTaken = 1; PCWrite = 0;
        step();
        check("exc_pc", PCResult, 32'h80000180);
        check("exc_cnt", 32'(RASCount), 32'd0);
        check("exc_mis", 32'(MisalignErr), 32'd0);
        idle(); Jump = 1; JumpTarget = 32'hFFFFFFFC;
        step();
        check("hold_pc", PCResult, 32'h80000180);
        PCWrite = 1;
        step();
        check("top_pc", PCResult, 32'hFFFFFFFC);
        Jump = 0;
        step();
        check("wrap_pc", PCResult, 32'h0);
        Jump = 1; Call = 1; JumpTarget = 32'h20;
        step();
        check("pre_rst_cnt", 32'(RASCount), 32'd1);
        Reset = 1; JumpTarget = 32'h30;
        step();
        check("mid_rst_pc", PCResult, 32'h0);
        check("mid_rst_cnt", 32'(RASCount), 32'd0);
        Reset = 0; idle(); Return = 1; JumpTarget = 32'h44;
        step();
        check("post_rst_ret", PCResult, 32'h44);
        check("post_rst_miss", 32'(RASMiss), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
